// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus bundle: memory read port plus core-facing instruction stream.
// The master modport is the fetch unit; the slave modport is memory and core together.
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        redirect;
  logic [63:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instruction, instr_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instruction, instr_pc,
    output mem_gnt, mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Credit-limited instruction prefetcher with redirect flush and in-order response buffering.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               fault
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {FETCH, STALL, FAULT} state_t;
  state_t state, state_nxt;

  logic [63:0]   fetch_pc, fetch_pc_nxt, rsp_pc, rsp_pc_nxt, pend_addr, target_pc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [OW-1:0] outst, outst_nxt, discard, discard_nxt;
  logic          pending, stale, stale_nxt, started;
  logic          credit, grant, accept, drop, push, pop, stale_gnt, misalign;
  logic [63:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   word_mem [FIFO_DEPTH];

  function automatic logic has_credit(input logic [CW-1:0] c, input logic [OW-1:0] o);
    return ((32'(c) + 32'(o)) < 32'(FIFO_DEPTH)) && (32'(o) < 32'(MAX_OUTSTANDING));
  endfunction

  assign credit          = has_credit(count, outst);
  assign bus.mem_req     = started && (pending || (state == FETCH && credit));
  assign bus.mem_addr    = pending ? pend_addr : fetch_pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instruction = bus.instr_valid ? word_mem[rd_ptr] : 32'h0;
  assign bus.instr_pc    = bus.instr_valid ? pc_mem[rd_ptr] : 64'h0;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc = bus.redirect_pc;
  assign misalign  = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign fault     = (state == FAULT);
`else
  assign target_pc = bus.redirect_pc & ~64'h3;
  assign misalign  = 1'b0;
`endif

  always_comb begin
    grant        = bus.mem_req & bus.mem_gnt;
    accept       = bus.mem_rvalid & (outst != '0);
    drop         = accept & (discard != '0);
    push         = accept & ~drop & ~bus.redirect;
    pop          = bus.instr_valid & bus.instr_ready & ~bus.redirect;
    stale_gnt    = grant & pending & stale;
    outst_nxt    = outst + OW'(grant) - OW'(accept);
    count_nxt    = bus.redirect ? '0 : count + CW'(push) - CW'(pop);
    // Redirect counts this cycle's grant/response first, so everything still in flight is dropped.
    discard_nxt  = bus.redirect ? outst_nxt : discard - OW'(drop) + OW'(stale_gnt);
    fetch_pc_nxt = fetch_pc;
    rsp_pc_nxt   = rsp_pc;
    stale_nxt    = stale;
    state_nxt    = state;

    if (bus.redirect)
      fetch_pc_nxt = target_pc;
    else if (grant && !(pending && stale))
      fetch_pc_nxt = fetch_pc + 64'd4;

    if (bus.redirect)
      rsp_pc_nxt = target_pc;
    else if (push)
      rsp_pc_nxt = rsp_pc + 64'd4;

    // A request caught ungranted by a redirect keeps its old address; remember to drop its answer.
    if (bus.mem_req && !bus.mem_gnt) begin
      if (bus.redirect)
        stale_nxt = 1'b1;
    end else begin
      stale_nxt = 1'b0;
    end

    if (misalign)
      state_nxt = FAULT;
    else if (bus.redirect)
      state_nxt = FETCH;
    else if (state != FAULT)
      state_nxt = has_credit(count_nxt, outst_nxt) ? FETCH : STALL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outst    <= '0;
      discard  <= '0;
      pending  <= 1'b0;
      stale    <= 1'b0;
      started  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      rsp_pc   <= rsp_pc_nxt;
      rd_ptr   <= bus.redirect ? '0 : rd_ptr + AW'(pop);
      wr_ptr   <= bus.redirect ? '0 : wr_ptr + AW'(push);
      count    <= count_nxt;
      outst    <= outst_nxt;
      discard  <= discard_nxt;
      pending  <= bus.mem_req & ~bus.mem_gnt;
      stale    <= stale_nxt;
      started  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      word_mem[wr_ptr] <= bus.mem_rdata;
    end
    if (!pending)
      pend_addr <= bus.mem_addr;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, corner sequences and randomized traffic
// checked against a queue-based transaction model.
module tb_instr_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fault(fault)
`endif
  );

  typedef struct { logic [63:0] pc; logic [31:0] word; } entry_t;
  typedef struct { logic [63:0] addr; bit live; } req_t;
  typedef struct {
    bit g; int rvm; bit rdy;
    bit e_req; logic [63:0] e_addr; bit e_vld; logic [63:0] e_pc; logic [31:0] e_ins;
  } vec_t;

  entry_t      m_fifo[$];
  req_t        m_out[$];
  logic [63:0] memq[$];
  logic [63:0] m_pc;
  bit          m_started, m_fault, m_pend;
  req_t        m_pend_r;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        tbl[6];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 64'h0;
    m_fifo.delete(); m_out.delete(); memq.delete();
    m_pc = RESET_PC; m_started = 0; m_fault = 0; m_pend = 0;
    repeat (2) @(negedge clk);
    chk("rst.mem_req", bus.mem_req, 0);
    chk("rst.mem_addr", bus.mem_addr, RESET_PC);
    chk("rst.instr_valid", bus.instr_valid, 0);
    chk("rst.instruction", bus.instruction, 0);
    chk("rst.instr_pc", bus.instr_pc, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst.fault", fault, 0);
`endif
    reset = 1'b0;
  endtask

  // rvm: 0 no response, 1 respond if memory has a read queued, 2 stray response
  task automatic step(input bit g, input int rvm, input bit rdy, input bit rd, input logic [63:0] rpc);
    bit e_req, crd, acc, rv, env_gnt;
    logic [63:0] e_addr, env_addr;
    logic [31:0] rdat;
    req_t r;
    crd    = ((m_fifo.size() + m_out.size()) < DEPTH) && (m_out.size() < MAXO);
    e_req  = m_started && (m_pend || (!m_fault && crd));
    e_addr = m_pend ? m_pend_r.addr : m_pc;
    chk("mem_req", bus.mem_req, e_req);
    if (e_req) chk("mem_addr", bus.mem_addr, e_addr);
    chk("instr_valid", bus.instr_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("instr_pc", bus.instr_pc, m_fifo[0].pc);
      chk("instruction", bus.instruction, m_fifo[0].word);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fault", fault, m_fault);
`endif
    rv   = (rvm == 2) || (rvm == 1 && memq.size() > 0);
    rdat = (rvm == 1 && memq.size() > 0) ? word_of(memq[0]) : 32'hDEAD_BEEF;
    bus.mem_gnt = g; bus.mem_rvalid = rv; bus.mem_rdata = rdat;
    bus.instr_ready = rdy; bus.redirect = rd; bus.redirect_pc = rpc;
    env_gnt  = bus.mem_req && g;
    env_addr = bus.mem_addr;
    @(posedge clk);
    if (rvm == 1 && rv) void'(memq.pop_front());
    if (env_gnt) memq.push_back(env_addr);
    acc = rv && (m_out.size() > 0);
    if (m_fifo.size() > 0 && rdy && !rd) void'(m_fifo.pop_front());
    if (acc) begin
      r = m_out.pop_front();
      if (r.live && !rd) m_fifo.push_back('{r.addr, rdat});
    end
    if (e_req && g) begin
      r.addr = e_addr;
      r.live = m_pend ? m_pend_r.live : 1'b1;
      if (r.live) m_pc = m_pc + 64'd4;
      m_out.push_back(r);
      m_pend = 0;
    end else if (e_req) begin
      m_pend_r.live = m_pend ? m_pend_r.live : 1'b1;
      m_pend_r.addr = e_addr;
      m_pend = 1;
    end
    if (rd) begin
      m_fifo.delete();
      foreach (m_out[i]) m_out[i].live = 1'b0;
      m_pend_r.live = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = (rpc[1:0] != 2'b00);
      m_pc = rpc;
`else
      m_pc = rpc & ~64'h3;
`endif
    end
    m_started = 1;
    @(negedge clk);
  endtask

  task automatic expect_first_pc(input string name, input logic [63:0] pc);
    int k;
    k = 0;
    while (!bus.instr_valid && k < 30) begin
      step(1, 1, 0, 0, 64'h0);
      k++;
    end
    if (bus.instr_valid) chk(name, bus.instr_pc, pc);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no instruction within 30 cycles, expected pc %h", name, pc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] rpc;
    tbl[0] = '{1, 0, 1, 0, 64'h0,  0, 64'h0, 32'h0};
    tbl[1] = '{1, 0, 1, 1, 64'h0,  0, 64'h0, 32'h0};
    tbl[2] = '{1, 1, 1, 1, 64'h4,  0, 64'h0, 32'h0};
    tbl[3] = '{1, 1, 1, 1, 64'h8,  1, 64'h0, 32'hC0DE_0000};
    tbl[4] = '{1, 1, 1, 1, 64'hC,  1, 64'h4, 32'hC0DE_0004};
    tbl[5] = '{1, 1, 1, 1, 64'h10, 1, 64'h8, 32'hC0DE_0008};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("tbl%0d.mem_req", i), bus.mem_req, tbl[i].e_req);
      chk($sformatf("tbl%0d.mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.instr_valid", i), bus.instr_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d.instr_pc", i), bus.instr_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d.instruction", i), bus.instruction, tbl[i].e_ins);
      end
      step(tbl[i].g, tbl[i].rvm, tbl[i].rdy, 0, 64'h0);
    end

    // Back-pressure fills the buffer, then draining returns credit
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 64'h0);
    chk("stall.mem_req", bus.mem_req, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_valid) begin
        chk("stall.instr_pc", bus.instr_pc, 64'(n * 4));
        n++;
      end
      step(0, 0, 1, 0, 64'h0);
    end
    chk("stall.depth", 64'(n), 64'(DEPTH));
    chk("resume.mem_req", bus.mem_req, 1);
    expect_first_pc("resume.pc", 64'h10);

    // Ungranted request holds through no-grant cycles and a redirect
    do_reset();
    step(0, 0, 1, 0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      chk("hold.mem_req", bus.mem_req, 1);
      chk("hold.mem_addr", bus.mem_addr, 64'h0);
      step(0, 0, 1, (i == 2), 64'h400);
    end
    expect_first_pc("hold.redirect_pc", 64'h400);

    // Redirect with two reads outstanding
    do_reset();
    step(1, 0, 1, 0, 64'h0);
    step(1, 0, 1, 0, 64'h0);
    step(1, 0, 1, 0, 64'h0);
    step(0, 0, 1, 1, 64'h100);
    expect_first_pc("redir.first_pc", 64'h100);

    // Redirect coincident with pop and response
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 64'h0);
    chk("coinc.pre_valid", bus.instr_valid, 1);
    step(1, 1, 1, 1, 64'h300);
    chk("coinc.valid_after", bus.instr_valid, 0);
    expect_first_pc("coinc.first_pc", 64'h300);

    // Reset with reads in flight, then stray responses after release
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 64'h0);
    do_reset();
    step(0, 2, 1, 0, 64'h0);
    step(0, 2, 1, 0, 64'h0);
    chk("stray.valid", bus.instr_valid, 0);
    expect_first_pc("stray.first_pc", RESET_PC);

`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 64'h0);
    step(1, 1, 1, 1, 64'h102);
    chk("mis.fault", fault, 1);
    chk("mis.mem_req", bus.mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, 64'h0);
      chk("mis.fault_held", fault, 1);
      chk("mis.no_req", bus.mem_req, 0);
    end
    step(1, 1, 1, 1, 64'h200);
    chk("mis.fault_clear", fault, 0);
    expect_first_pc("mis.resume_pc", 64'h200);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4 : {32'h0, $urandom};
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
`endif
      step($urandom_range(0, 9) < 7, ($urandom_range(0, 9) < 6) ? 1 : 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the instruction buffer depth (power of two, >= 2).
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 2, giving the maximum granted-but-unanswered memory reads.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 mem_req  output  1  instruction memory read request.
REQ-007 mem_addr  output  64  byte address of the requested word.
REQ-008 mem_gnt  input  1  memory accepts the request this cycle.
REQ-009 mem_rvalid  input  1  read data valid; one response per grant, in grant order.
REQ-010 mem_rdata  input  32  read data word.
REQ-011 instr_valid  output  1  instruction and instr_pc are valid.
REQ-012 instr_ready  input  1  core consumes the instruction this cycle.
REQ-013 instruction  output  32  fetched instruction word.
REQ-014 instr_pc  output  64  byte address of instruction.
REQ-015 redirect  input  1  core requests a fetch from redirect_pc (jump, branch taken).
REQ-016 redirect_pc  input  64  new fetch address.
REQ-017 fault  output  1  misaligned fetch target; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-018 The block SHALL keep a fetch PC, a FIFO of {pc, word} entries, an outstanding counter and a discard counter.
REQ-019 mem_req SHALL assert when the FSM is in FETCH and FIFO occupancy + outstanding < FIFO_DEPTH and outstanding < MAX_OUTSTANDING, or when a request is already pending ungranted.
REQ-020 Once asserted, mem_req and mem_addr SHALL hold stable until the cycle mem_gnt is high.
REQ-021 On mem_req & mem_gnt the fetch PC SHALL advance by 4 (64-bit wrap-around) and outstanding SHALL increment.
REQ-022 On mem_rvalid outstanding SHALL decrement; if discard > 0 the word SHALL be dropped and discard decremented, else {pc, mem_rdata} SHALL be pushed to the FIFO.
REQ-023 Grant and response in the same cycle SHALL leave outstanding unchanged.
REQ-024 instr_valid SHALL equal FIFO non-empty; instruction/instr_pc SHALL be the FIFO head; a pop SHALL occur on instr_valid & instr_ready.
REQ-025 A response arriving while the FIFO is empty SHALL produce instr_valid on the next cycle (1-cycle latency).
REQ-026 Push and pop in the same cycle SHALL be legal at any occupancy, including full.
REQ-027 On redirect the FIFO SHALL be flushed, the fetch PC loaded with redirect_pc, and discard set to outstanding after this cycle's grant/response accounting; instr_valid SHALL be 0 the next cycle.
REQ-028 redirect SHALL take priority over a simultaneous pop, push or response; a request pending ungranted at redirect SHALL complete with its old address and its response SHALL be discarded.
REQ-029 FSM states: FETCH (normal), STALL (credit limit reached, no request), FAULT (configuration only); FETCH->STALL when REQ-019 credit fails, STALL->FETCH when credit returns, any->FETCH on valid redirect.

Reset
REQ-030 On reset: fetch PC = RESET_PC, FIFO empty, outstanding = 0, discard = 0, FSM = FETCH.
REQ-031 On reset: mem_req = 0, mem_addr = RESET_PC, instr_valid = 0, instruction = 0, instr_pc = 0, fault = 0.
REQ-032 mem_req SHALL first assert on the first rising edge after reset deasserts.
REQ-033 Reset mid-transaction SHALL abandon all outstanding reads; responses arriving after release without a post-reset grant SHALL be ignored.

Configuration
REQ-034 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] != 0 SHALL flush as REQ-027, enter FAULT, assert fault, and issue no requests until a subsequent aligned redirect or reset.
REQ-035 Macro FETCH_MISALIGN_TRAP_EN undefined: fault port absent, redirect_pc[1:0] forced to 0, FAULT state unreachable.

Verification
REQ-036 Reset release, memory grants every cycle, rvalid one cycle after grant -> instructions at pc 0x0, 0x4, 0x8 in order, instr_valid first high 3 cycles after release.
REQ-037 instr_ready held 0 -> exactly FIFO_DEPTH (4) entries buffered, mem_req low, FSM in STALL; instr_ready 1 -> fetching resumes.
REQ-038 Redirect to 0x100 with 2 reads outstanding -> both responses dropped, next instr_pc = 0x100.
REQ-039 mem_gnt held 0 for 5 cycles -> mem_req and mem_addr stable all 5 cycles.
REQ-040 Redirect coincident with pop and rvalid -> FIFO empty next cycle, no instruction from the old stream delivered.
REQ-041 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fault = 1, mem_req = 0; redirect to 0x200 -> fault = 0, fetch from 0x200.
